// File: rtl/prefetch_buffer_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
//   prefetch_in_type  : fetch-stage and memory inputs bundled together
//   prefetch_out_type : instruction, stall and fetch address outputs
//   prefetch_reg_type : width-independent architectural state (pointers and count
//                       live in the top because their width follows DEPTH)
package prefetch_buffer_pkg;

  localparam int unsigned PREFETCH_DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] npc;
    logic        spec;
    logic        valid;
    logic        fence;
    logic [31:0] rdata;
    logic        ready;
  } prefetch_in_type;

  typedef struct packed {
    logic [31:0] instr;
    logic        stall;
    logic [31:0] fpc;
  } prefetch_out_type;

  typedef struct packed {
    logic [31:0] fpc;        // word-aligned fetch address presented to memory
    logic [29:0] head_addr;  // word address of the entry at rptr
    logic        drop;       // discard the next response (request made before a redirect)
  } prefetch_reg_type;

  localparam prefetch_reg_type PREFETCH_REG_INIT = '{
    fpc:       32'h0,
    head_addr: 30'h0,
    drop:      1'b0
  };

  function automatic prefetch_reg_type prefetch_reg_init(input logic [31:0] reset_pc);
    prefetch_reg_type r;
    r           = PREFETCH_REG_INIT;
    r.fpc       = {reset_pc[31:2], 2'b00};
    r.head_addr = reset_pc[31:2];
    return r;
  endfunction

  // A halfword whose low two bits are not 2'b11 is a complete 16-bit instruction.
  function automatic logic is_compressed(input logic [15:0] half);
    return half[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/prefetch_ram.sv
// DEPTH x 32 register file for the prefetch buffer.
//   clk_i             : clock
//   we_i/waddr_i/wdata_i : single write port
//   raddr0_i/rdata0_o : read port for the head entry (combinational)
//   raddr1_i/rdata1_o : read port for the entry after the head (combinational)
module prefetch_ram #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AddrW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [AddrW-1:0] raddr0_i,
  output logic [31:0]      rdata0_o,
  input  logic [AddrW-1:0] raddr1_i,
  output logic [31:0]      rdata1_o
);

  logic [31:0] mem_q [DEPTH];

  // Contents need no reset: entries are only read while count marks them valid.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata0_o = mem_q[raddr0_i];
    rdata1_o = mem_q[raddr1_i];
  end

endmodule

// File: rtl/prefetch_buffer.sv
// Instruction prefetch buffer between instruction memory and the fetch stage.
// Issues word-aligned fetch addresses, queues returned words in a circular
// buffer and extracts the (16- or 32-bit) instruction at pc.
//   clk, rst      : clock, synchronous active-high reset
//   pc, npc       : current and next pc of the fetch stage
//   spec, fence   : redirect to npc (flush and restart)
//   valid         : fetch stage consumes instr this cycle when stall=0
//   rdata, ready  : memory response for the fpc presented on the previous cycle
//   instr, stall  : extracted instruction (0 when stalled) and not-available flag
//   fpc           : registered word-aligned fetch address
module prefetch_buffer
  import prefetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH    = PREFETCH_DEPTH,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic [31:0] npc,
  input  logic        spec,
  input  logic        valid,
  input  logic        fence,
  input  logic [31:0] rdata,
  input  logic        ready,
  output logic [31:0] instr,
  output logic        stall,
  output logic [31:0] fpc
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  prefetch_in_type  in_s;
  prefetch_out_type out_s;

  prefetch_reg_type r_q, r_d;
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;

  logic [PtrW-1:0]  rptr_next;
  logic [31:0]      head_word;
  logic [31:0]      next_word;
  logic [15:0]      h0, h1;
  logic             redirect;
  logic             push;
  logic             pop;
  logic             unused_bits;

  always_comb begin
    in_s = '{
      pc:    pc,
      npc:   npc,
      spec:  spec,
      valid: valid,
      fence: fence,
      rdata: rdata,
      ready: ready
    };
  end

  assign rptr_next = rptr_q + PtrW'(1);

  prefetch_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i    (clk),
    .we_i     (push),
    .waddr_i  (wptr_q),
    .wdata_i  (in_s.rdata),
    .raddr0_i (rptr_q),
    .rdata0_o (head_word),
    .raddr1_i (rptr_next),
    .rdata1_o (next_word)
  );

  assign h0 = head_word[15:0];
  assign h1 = head_word[31:16];

  // Extraction: purely combinational from registered state and pc.
  always_comb begin
    out_s.instr = 32'h0;
    out_s.stall = 1'b1;
    out_s.fpc   = r_q.fpc;
    if ((count_q != '0) && (r_q.head_addr == in_s.pc[31:2])) begin
      if (!in_s.pc[1]) begin
        out_s.stall = 1'b0;
        out_s.instr = is_compressed(h0) ? {16'h0, h0} : head_word;
      end else if (is_compressed(h1)) begin
        out_s.stall = 1'b0;
        out_s.instr = {16'h0, h1};
      end else if (count_q >= CntW'(2)) begin
        // 32-bit instruction straddling into the following word.
        out_s.stall = 1'b0;
        out_s.instr = {next_word[15:0], h1};
      end
    end
  end

  assign instr = out_s.instr;
  assign stall = out_s.stall;
  assign fpc   = out_s.fpc;

  assign redirect = in_s.spec | in_s.fence;
  // A full buffer discards the response and holds fpc so the word is refetched.
  assign push = in_s.ready & ~r_q.drop & ~redirect & (count_q != DepthCnt);
  assign pop  = in_s.valid & ~out_s.stall & ~redirect & (in_s.npc[31:2] != in_s.pc[31:2]);

  always_comb begin
    r_d     = r_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (redirect) begin
      count_d       = '0;
      wptr_d        = '0;
      rptr_d        = '0;
      r_d.head_addr = in_s.npc[31:2];
      r_d.fpc       = {in_s.npc[31:2], 2'b00};
      // The request at the old fpc is still outstanding unless answered now.
      r_d.drop      = ~in_s.ready;
    end else begin
      if (in_s.ready && r_q.drop) begin
        r_d.drop = 1'b0;
      end
      if (push) begin
        wptr_d  = wptr_q + PtrW'(1);
        r_d.fpc = r_q.fpc + 32'd4;
      end
      if (pop) begin
        rptr_d        = rptr_next;
        r_d.head_addr = r_q.head_addr + 30'd1;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q     <= prefetch_reg_init(RESET_PC);
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      r_q     <= r_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign unused_bits = ^{in_s.pc[0], in_s.npc[1:0], next_word[31:16]};

endmodule

// File: tb/tb_prefetch_buffer.sv
// Directed self-checking bench for prefetch_buffer (DEPTH=4, RESET_PC=0).
// Memory is modelled by the bench: each step drives ready/rdata for the
// address the bench expects fpc to hold.
module tb_prefetch_buffer;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        spec;
  logic        valid;
  logic        fence;
  logic [31:0] rdata;
  logic        ready;
  logic [31:0] instr;
  logic        stall;
  logic [31:0] fpc;

  int n_checks;
  int n_fail;

  prefetch_buffer #(
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .pc    (pc),
    .npc   (npc),
    .spec  (spec),
    .valid (valid),
    .fence (fence),
    .rdata (rdata),
    .ready (ready),
    .instr (instr),
    .stall (stall),
    .fpc   (fpc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Tagged 32-bit word for address a: low bits 11 so it is a full-width instruction.
  function automatic logic [31:0] w(input logic [31:0] a);
    return 32'hC0DE0003 | (a << 4);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs and let combinational outputs settle.
  task automatic drive(input logic [31:0] p, input logic [31:0] np, input logic v,
                       input logic s, input logic f, input logic r, input logic [31:0] d);
    pc    = p;
    npc   = np;
    valid = v;
    spec  = s;
    fence = f;
    ready = r;
    rdata = d;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    drive(32'h0, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h1);
    chk("rst_instr", instr, 32'h0);
    chk("rst_fpc", fpc, 32'h0);

    // Streaming 0x13 with ready every cycle
    drive(32'h0, 32'h4, 1'b1, 1'b0, 1'b0, 1'b1, 32'h13);
    chk("s_a_stall", {31'h0, stall}, 32'h1);
    chk("s_a_fpc", fpc, 32'h0);
    tick();
    drive(32'h0, 32'h4, 1'b1, 1'b0, 1'b0, 1'b1, 32'h13);
    chk("s_b_stall", {31'h0, stall}, 32'h0);
    chk("s_b_instr", instr, 32'h13);
    chk("s_b_fpc", fpc, 32'h4);
    tick();
    drive(32'h4, 32'h8, 1'b1, 1'b0, 1'b0, 1'b1, 32'h13);
    chk("s_c_instr", instr, 32'h13);
    chk("s_c_fpc", fpc, 32'h8);
    tick();
    drive(32'h8, 32'hC, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("s_d_stall", {31'h0, stall}, 32'h0);
    chk("s_d_fpc", fpc, 32'hC);
    tick();

    // Two compressed halves in one word; single pop on leaving pc 2
    do_reset();
    drive(32'h0, 32'h2, 1'b1, 1'b0, 1'b0, 1'b1, 32'h45014501);
    tick();
    drive(32'h0, 32'h2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("c_pc0_instr", instr, 32'h00004501);
    chk("c_pc0_stall", {31'h0, stall}, 32'h0);
    tick();
    drive(32'h2, 32'h4, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("c_pc2_instr", instr, 32'h00004501);
    chk("c_pc2_fpc", fpc, 32'h4);
    tick();
    drive(32'h4, 32'h6, 1'b1, 1'b0, 1'b0, 1'b1, 32'h13);
    chk("c_pc4_empty", {31'h0, stall}, 32'h1);
    tick();
    drive(32'h4, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("c_pc4_instr", instr, 32'h13);
    chk("c_pc4_stall", {31'h0, stall}, 32'h0);

    // Straddling 32-bit instruction
    do_reset();
    drive(32'h0, 32'h2, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00134501);
    tick();
    drive(32'h0, 32'h2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("x_pc0_instr", instr, 32'h00004501);
    tick();
    drive(32'h2, 32'h6, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("x_wait_stall", {31'h0, stall}, 32'h1);
    chk("x_wait_instr", instr, 32'h0);
    tick();
    drive(32'h2, 32'h6, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00000000);
    chk("x_wait2_stall", {31'h0, stall}, 32'h1);
    tick();
    drive(32'h2, 32'h6, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("x_instr", instr, 32'h00000013);
    chk("x_stall", {31'h0, stall}, 32'h0);
    tick();
    drive(32'h6, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("x_pc6_stall", {31'h0, stall}, 32'h0);
    chk("x_pc6_instr", instr, 32'h0);

    // Fill to DEPTH, drop while full, refetch without skipping
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(32'h0, 32'h4, 1'b0, 1'b0, 1'b0, 1'b1, w(32'(i * 4)));
      tick();
    end
    drive(32'h0, 32'h4, 1'b0, 1'b0, 1'b0, 1'b1, w(32'h10));
    chk("f_full_fpc", fpc, 32'h10);
    chk("f_full_instr", instr, w(32'h0));
    tick();
    drive(32'h0, 32'h4, 1'b1, 1'b0, 1'b0, 1'b1, w(32'h10));
    chk("f_held_fpc", fpc, 32'h10);
    tick();
    drive(32'h4, 32'h8, 1'b1, 1'b0, 1'b0, 1'b1, w(32'h10));
    chk("f_pc4_instr", instr, w(32'h4));
    chk("f_pc4_fpc", fpc, 32'h10);
    tick();
    drive(32'h8, 32'hC, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("f_pc8_instr", instr, w(32'h8));
    chk("f_pc8_fpc", fpc, 32'h14);
    tick();
    drive(32'hC, 32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("f_pcC_instr", instr, w(32'hC));
    tick();
    drive(32'h10, 32'h14, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("f_pc10_instr", instr, w(32'h10));
    chk("f_pc10_stall", {31'h0, stall}, 32'h0);

    // spec redirect with a pending request: stale response dropped
    do_reset();
    drive(32'h0, 32'h4, 1'b0, 1'b0, 1'b0, 1'b1, w(32'h0));
    tick();
    drive(32'h0, 32'h100, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    drive(32'h100, 32'h104, 1'b1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
    chk("r_fpc", fpc, 32'h100);
    chk("r_stall", {31'h0, stall}, 32'h1);
    tick();
    drive(32'h100, 32'h104, 1'b1, 1'b0, 1'b0, 1'b1, w(32'h100));
    chk("r_drop_fpc", fpc, 32'h100);
    chk("r_drop_stall", {31'h0, stall}, 32'h1);
    tick();
    drive(32'h100, 32'h104, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("r_instr", instr, w(32'h100));
    chk("r_fpc2", fpc, 32'h104);

    // fence with a response in the redirect cycle: discarded, no drop armed
    drive(32'h100, 32'h200, 1'b1, 1'b0, 1'b1, 1'b1, 32'hBAD00003);
    tick();
    drive(32'h200, 32'h204, 1'b0, 1'b0, 1'b0, 1'b1, w(32'h200));
    chk("fe_fpc", fpc, 32'h200);
    chk("fe_stall", {31'h0, stall}, 32'h1);
    tick();
    drive(32'h200, 32'h204, 1'b0, 1'b0, 1'b0, 1'b1, w(32'h204));
    chk("fe_instr", instr, w(32'h200));
    chk("fe_fpc2", fpc, 32'h204);
    tick();

    // Reset mid-stream with two words buffered
    drive(32'h200, 32'h204, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(32'h200, 32'h204, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("m_stall_old", {31'h0, stall}, 32'h1);
    drive(32'h0, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("m_stall", {31'h0, stall}, 32'h1);
    chk("m_instr", instr, 32'h0);
    chk("m_fpc", fpc, 32'h0);
    drive(32'h0, 32'h4, 1'b0, 1'b0, 1'b0, 1'b1, w(32'h0));
    tick();
    drive(32'h0, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("m_after_instr", instr, w(32'h0));
    chk("m_after_fpc", fpc, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prefetch_buffer.md
Name: prefetch_buffer

Overview:
Instruction prefetch buffer between instruction memory and the fetch stage. It issues word-aligned fetch addresses, queues returned 32-bit words in a small circular buffer, and extracts the instruction at the fetch stage's pc. Both 16-bit compressed and 32-bit encodings are supported, including 32-bit instructions that straddle two words. It flushes and restarts on redirect (spec) or fence.

Parameters:
DEPTH, 4, number of 32-bit word entries; power of two, >= 2
RESET_PC, 32'h0, reset value of fpc and of the buffer head address

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
pc  in  32  current pc held by the fetch stage
npc  in  32  next pc computed by the fetch stage this cycle
spec  in  1  redirect: flush, restart fetching at npc
valid  in  1  fetch stage consumes instr this cycle if stall=0
fence  in  1  treated exactly as spec
rdata  in  32  memory read data
ready  in  1  rdata valid for the fpc presented on the previous cycle
instr  out  32  instruction at pc; compressed: {16'h0, half}
stall  out  1  instr not available
fpc  out  32  registered word-aligned fetch address; fpc[1:0]=0 always

Behaviour:
- State: buffer[DEPTH], wptr/rptr (log2 DEPTH bits, wrap modulo DEPTH), count (0..DEPTH), head_addr (word address of the rptr entry), fpc, drop flag.
- Reset (rst=1 at posedge): count=0, wptr=rptr=0, drop=0, fpc=RESET_PC, head_addr=RESET_PC[31:2]. The following cycle: stall=1, instr=0.
- Memory: request is always active at fpc; fpc is held until a response is accepted.
- Push: ready=1, drop=0, spec=0, fence=0, and count<DEPTH → write rdata at wptr, wptr+1, fpc+=4.
- ready=1 with count==DEPTH: response is discarded and fpc is held, so the word is refetched.
- Extraction (combinational from registers and pc), with h0/h1 the low/high halves of the head word:
  - If head_addr!=pc[31:2] or count==0: stall=1.
  - pc[1]=0: if h0[1:0]!=2'b11, instr={16'h0,h0}; else instr = head word.
  - pc[1]=1, h1[1:0]!=2'b11: instr={16'h0,h1}.
  - pc[1]=1, h1[1:0]==2'b11: needs count>=2; instr={next word[15:0],h1}; otherwise stall=1.
  - When stall=1, instr=0.
- Pop: valid=1, stall=0, spec=0, fence=0, and npc[31:2]!=pc[31:2] → rptr+1, head_addr+1.
- Push and pop in the same cycle: count unchanged. Pop is never allowed from an empty buffer.
- Redirect (spec|fence=1):
  - Next cycle: count=0, wptr=rptr=0, head_addr=npc[31:2], fpc={npc[31:2],2'b00}.
  - Any ready arriving in the redirect cycle is discarded.
  - drop is set if fpc has an unanswered request (no ready this cycle); the first ready after the redirect is then discarded and drop clears.
  - Redirect has priority over push and pop.
- Reset in mid-operation overrides everything; in-flight responses after reset are accepted normally.
- Latency: redirect to first valid instr is at least 2 cycles (fpc update, then memory response). A buffered compressed or word-aligned instruction is available combinationally.

Decomposition:
- Shared package: prefetch_in_type (pc, npc, spec, valid, fence, rdata, ready), prefetch_out_type (instr, stall, fpc), prefetch_reg_type with its init constant, PREFETCH_DEPTH.
- One natural sub-module: prefetch_ram, a DEPTH x 32 register file with one write port and two read ports (rptr, rptr+1).

Test Plan:
- Reset with RESET_PC=0, memory returning 0x00000013 with ready every cycle → fpc 0,4,8,12; stall drops after the first response; instr=0x00000013; pc advances by 4 per cycle.
- Word 0x45014501 at address 0 → instr=0x00004501 at pc 0, then at pc 2; exactly one pop, on leaving pc 2.
- Straddle: word0=0x00134501, word1=0x00000000, with pc 0 then 2 → at pc 2 instr=0x00000013, and stall=1 until word1 is buffered.
- Fetch stage holds valid=0 → buffer fills to DEPTH; subsequent ready is dropped with fpc held; at valid=1, refetch resumes without skipping an address.
- spec=1 with npc=0x100 while a request is pending → next fpc=0x100; the stale response is dropped; the first instr comes from 0x100.
- rst=1 mid-stream with the buffer half full → next cycle count=0, stall=1, fpc=RESET_PC.
